axi_default_slave: RTL and testbench
====================================

Name: axi_default_slave

Overview:
- AXI4 terminating slave that sits directly downstream of axi_interconnect.
- It is attached to the interconnect master port that receives decode misses: transactions whose address falls outside every SLV_ADDR_L/SLV_ADDR_H window, or that SLV_ACCESS forbids.
- It completes every write and read protocol-correctly with an error response, so an illegal access never hangs the interconnect or the requesting master.
- Independent write and read engines; one outstanding transaction per direction.

Parameters:
- DW, 32, data width (multiple of 8)
- AW, 32, address width
- IDW, 4, ID width
- USRW, 4, user width
- ERR_RESP, 2'b11, response code returned on B and R (DECERR)
- RDATA_FILL, {DW{1'b0}}, constant returned on every read beat

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_awvalid/s_awready  in/out  1  AW handshake
- s_awaddr  in  AW  write address (used only by optional log)
- s_awid  in  IDW  write ID
- s_awlen  in  8  burst length minus one (ignored; W drained on wlast)
- s_awsize, s_awburst, s_awcache, s_awprot, s_awlock, s_awqos, s_awregion, s_awuser  in  per AXI4  ignored
- s_wvalid/s_wready  in/out  1  W handshake
- s_wlast  in  1  last write beat
- s_wdata, s_wstrb, s_wuser  in  DW/DW/8/USRW  discarded
- s_bwvalid/s_bwready  out/in  1  B handshake
- s_bresp  out  2  = ERR_RESP
- s_bid  out  IDW  captured awid
- s_buser  out  USRW  0
- s_arvalid/s_aready  in/out  1  AR handshake
- s_araddr  in  AW  read address (optional log)
- s_arid  in  IDW  read ID
- s_arlen  in  8  burst length minus one
- other AR sideband  in  per AXI4  ignored
- s_rvalid/s_rready  out/in  1  R handshake
- s_rlast  out  1  final read beat
- s_rdata  out  DW  = RDATA_FILL
- s_rresp  out  2  = ERR_RESP
- s_rid  out  IDW  captured arid
- s_ruser  out  USRW  0

Behaviour:
- Single clock aclk; aresetn synchronous, active-low. All state updates on aclk rising edge.
- Reset values: s_awready=1, s_wready=0, s_bwvalid=0, s_aready=1, s_rvalid=0, s_rlast=0, captured IDs=0, beat counter=0. Reset mid-burst abandons the burst: no B/R is emitted afterwards.
- Write FSM:
  - W_IDLE (awready=1): AW handshake → capture awid → W_DATA.
  - W_DATA (wready=1): each W handshake is discarded. Handshake with wlast=1 → W_RESP.
  - W_RESP (bwvalid=1, bid=captured ID, bresp=ERR_RESP): held stable until bwready → W_IDLE.
- Write timing:
  - AW handshake in cycle N → wready first high in N+1.
  - wlast handshake in cycle M → bwvalid high in M+1.
  - awready is low in W_DATA and W_RESP.
  - wready is low outside W_DATA, so W beats are not accepted ahead of AW.
- Read FSM:
  - R_IDLE (aready=1): AR handshake → capture arid, load cnt=arlen → R_DATA.
  - R_DATA (rvalid=1): rlast = (cnt==0). Handshake with cnt!=0 → cnt-1. Handshake with rlast → R_IDLE.
- Read timing:
  - AR handshake in cycle N → rvalid in N+1.
  - arlen=255 yields exactly 256 beats; the counter never wraps.
  - R outputs are held stable while rvalid=1 and rready=0.
- Minimum one dead cycle between successive transactions in the same direction. aready re-asserts the cycle after the last beat handshake; awready re-asserts the cycle after the B handshake.
- Read and write engines are fully independent. Simultaneous AW and AR handshakes are both accepted.

Optional Feature:
- Macro: AXI_DEFAULT_SLV_ERRLOG_EN.
- When defined, adds these ports:
  - err_valid  out  1
  - err_is_wr  out  1
  - err_addr  out  AW
  - err_clr  in  1
- Capture rules:
  - While err_valid=0, the first AW or AR handshake latches its address and direction and sets err_valid.
  - If AW and AR handshake in the same cycle, the write is captured.
  - err_clr=1 clears err_valid next cycle. A capture in the same cycle as err_clr takes priority and sets err_valid with the new address.
  - All log outputs reset to 0.
- When not defined: the ports are absent and there is no extra logic.

Test Plan:
- Single-beat write: AW id=3 → wready in N+1; W wlast=1 → bwvalid next cycle with bid=3, bresp=2'b11.
- 4-beat write with bwready held low 5 cycles → B stable the whole time; awready stays 0 until the B handshake, then returns to 1.
- Read id=5, arlen=7, rready toggling → exactly 8 beats, rdata=0, rresp=2'b11, rid=5, rlast only on beat 8.
- arlen=255 concurrent with a 2-beat write → 256 read beats and one B, with no cross-interference.
- aresetn low in the middle of a 16-beat read → rvalid=0 and aready=1 the next cycle; no further beats.
- With AXI_DEFAULT_SLV_ERRLOG_EN: AR 0x4000_0000 then AW 0x5000_0000 → err_addr=0x4000_0000, err_is_wr=0. After err_clr, an AW at 0x6000_0000 → err_addr=0x6000_0000, err_is_wr=1.

Source files
------------

// File: rtl/axi_default_slave.sv
// AXI4 terminating slave: completes every write/read with ERR_RESP and a constant read fill.
// Optional error log enabled by defining AXI_DEFAULT_SLV_ERRLOG_EN.
module axi_default_slave #(
  parameter int              DW         = 32,
  parameter int              AW         = 32,
  parameter int              IDW        = 4,
  parameter int              USRW       = 4,
  parameter logic [1:0]      ERR_RESP   = 2'b11,
  parameter logic [DW-1:0]   RDATA_FILL = {DW{1'b0}}
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [AW-1:0]     s_awaddr,
  input  logic [IDW-1:0]    s_awid,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  input  logic [3:0]        s_awcache,
  input  logic [2:0]        s_awprot,
  input  logic              s_awlock,
  input  logic [3:0]        s_awqos,
  input  logic [3:0]        s_awregion,
  input  logic [USRW-1:0]   s_awuser,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic              s_wlast,
  input  logic [DW-1:0]     s_wdata,
  input  logic [DW/8-1:0]   s_wstrb,
  input  logic [USRW-1:0]   s_wuser,
  output logic              s_bwvalid,
  input  logic              s_bwready,
  output logic [1:0]        s_bresp,
  output logic [IDW-1:0]    s_bid,
  output logic [USRW-1:0]   s_buser,
  input  logic              s_arvalid,
  output logic              s_aready,
  input  logic [AW-1:0]     s_araddr,
  input  logic [IDW-1:0]    s_arid,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic [3:0]        s_arcache,
  input  logic [2:0]        s_arprot,
  input  logic              s_arlock,
  input  logic [3:0]        s_arqos,
  input  logic [3:0]        s_arregion,
  input  logic [USRW-1:0]   s_aruser,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              s_rlast,
  output logic [DW-1:0]     s_rdata,
  output logic [1:0]        s_rresp,
  output logic [IDW-1:0]    s_rid,
  output logic [USRW-1:0]   s_ruser
`ifdef AXI_DEFAULT_SLV_ERRLOG_EN
  ,
  output logic              err_valid,
  output logic              err_is_wr,
  output logic [AW-1:0]     err_addr,
  input  logic              err_clr
`endif
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t       w_state_r, w_next_s;
  r_state_t       r_state_r, r_next_s;
  logic           awready_r, wready_r, bvalid_r;
  logic           aready_r, rvalid_r, rlast_r;
  logic [IDW-1:0] bid_r, rid_r;
  logic [7:0]     cnt_r, cnt_next_s;
  logic           aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

  assign aw_hs_s = s_awvalid & awready_r;
  assign w_hs_s  = s_wvalid  & wready_r;
  assign b_hs_s  = bvalid_r  & s_bwready;
  assign ar_hs_s = s_arvalid & aready_r;
  assign r_hs_s  = rvalid_r  & s_rready;

  // Write engine next-state decode
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
      W_DATA: if (w_hs_s && s_wlast) w_next_s = W_RESP; else w_next_s = W_DATA;
      W_RESP: if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write engine state and registered handshake outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= {IDW{1'b0}};
    end else begin
      w_state_r <= w_next_s;
      awready_r <= (w_next_s == W_IDLE);
      wready_r  <= (w_next_s == W_DATA);
      bvalid_r  <= (w_next_s == W_RESP);
      if (aw_hs_s) bid_r <= s_awid;
    end
  end

  // Read engine next-state and beat counter decode; counter stops at zero
  always_comb begin
    r_next_s   = r_state_r;
    cnt_next_s = cnt_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_next_s   = R_DATA;
          cnt_next_s = s_arlen;
        end else begin
          r_next_s   = R_IDLE;
          cnt_next_s = cnt_r;
        end
      end
      R_DATA: begin
        if (r_hs_s && (cnt_r == 8'd0)) begin
          r_next_s   = R_IDLE;
          cnt_next_s = 8'd0;
        end else if (r_hs_s) begin
          r_next_s   = R_DATA;
          cnt_next_s = cnt_r - 8'd1;
        end else begin
          r_next_s   = R_DATA;
          cnt_next_s = cnt_r;
        end
      end
      default: begin
        r_next_s   = R_IDLE;
        cnt_next_s = 8'd0;
      end
    endcase
  end

  // Read engine state, counter and registered R outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_r <= R_IDLE;
      aready_r  <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= {IDW{1'b0}};
      cnt_r     <= 8'd0;
    end else begin
      r_state_r <= r_next_s;
      aready_r  <= (r_next_s == R_IDLE);
      rvalid_r  <= (r_next_s == R_DATA);
      rlast_r   <= (r_next_s == R_DATA) && (cnt_next_s == 8'd0);
      cnt_r     <= cnt_next_s;
      if (ar_hs_s) rid_r <= s_arid;
    end
  end

  assign s_awready = awready_r;
  assign s_wready  = wready_r;
  assign s_bwvalid = bvalid_r;
  assign s_bid     = bid_r;
  assign s_bresp   = ERR_RESP;
  assign s_buser   = {USRW{1'b0}};
  assign s_aready  = aready_r;
  assign s_rvalid  = rvalid_r;
  assign s_rlast   = rlast_r;
  assign s_rid     = rid_r;
  assign s_rdata   = RDATA_FILL;
  assign s_rresp   = ERR_RESP;
  assign s_ruser   = {USRW{1'b0}};

`ifdef AXI_DEFAULT_SLV_ERRLOG_EN
  logic          err_valid_r, err_is_wr_r;
  logic [AW-1:0] err_addr_r;

  // First-miss log; a write wins over a simultaneous read, capture wins over clear
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_valid_r <= 1'b0;
      err_is_wr_r <= 1'b0;
      err_addr_r  <= {AW{1'b0}};
    end else if (!err_valid_r && (aw_hs_s || ar_hs_s)) begin
      err_valid_r <= 1'b1;
      err_is_wr_r <= aw_hs_s;
      err_addr_r  <= aw_hs_s ? s_awaddr : s_araddr;
    end else if (err_clr) begin
      err_valid_r <= 1'b0;
    end
  end

  assign err_valid = err_valid_r;
  assign err_is_wr = err_is_wr_r;
  assign err_addr  = err_addr_r;

  logic unused_inputs_s;
  assign unused_inputs_s = ^{s_awlen, s_awsize, s_awburst, s_awcache, s_awprot, s_awlock,
                             s_awqos, s_awregion, s_awuser, s_wdata, s_wstrb, s_wuser,
                             s_arsize, s_arburst, s_arcache, s_arprot, s_arlock, s_arqos,
                             s_arregion, s_aruser};
`else
  logic unused_inputs_s;
  assign unused_inputs_s = ^{s_awaddr, s_araddr, s_awlen, s_awsize, s_awburst, s_awcache,
                             s_awprot, s_awlock, s_awqos, s_awregion, s_awuser, s_wdata,
                             s_wstrb, s_wuser, s_arsize, s_arburst, s_arcache, s_arprot,
                             s_arlock, s_arqos, s_arregion, s_aruser};
`endif

endmodule

// File: tb/tb_axi_default_slave.sv
// Self-checking bench for axi_default_slave: vector table of transactions plus a B/R scoreboard.
module tb_axi_default_slave;
  localparam int DW = 32, AW = 32, IDW = 4, USRW = 4;

  logic aclk = 1'b0;
  logic aresetn;
  logic s_awvalid, s_awready, s_awlock, s_wvalid, s_wready, s_wlast, s_bwvalid, s_bwready;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [IDW-1:0] s_awid, s_bid, s_arid, s_rid;
  logic [7:0] s_awlen, s_arlen;
  logic [2:0] s_awsize, s_awprot, s_arsize, s_arprot;
  logic [1:0] s_awburst, s_arburst, s_bresp, s_rresp;
  logic [3:0] s_awcache, s_awqos, s_awregion, s_arcache, s_arqos, s_arregion;
  logic [USRW-1:0] s_awuser, s_wuser, s_buser, s_aruser, s_ruser;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [DW/8-1:0] s_wstrb;
  logic s_arvalid, s_aready, s_arlock, s_rvalid, s_rready, s_rlast;
`ifdef AXI_DEFAULT_SLV_ERRLOG_EN
  logic err_valid, err_is_wr, err_clr;
  logic [AW-1:0] err_addr;
`endif

  axi_default_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awcache(s_awcache),
    .s_awprot(s_awprot), .s_awlock(s_awlock), .s_awqos(s_awqos), .s_awregion(s_awregion),
    .s_awuser(s_awuser), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wuser(s_wuser), .s_bwvalid(s_bwvalid),
    .s_bwready(s_bwready), .s_bresp(s_bresp), .s_bid(s_bid), .s_buser(s_buser),
    .s_arvalid(s_arvalid), .s_aready(s_aready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arcache(s_arcache),
    .s_arprot(s_arprot), .s_arlock(s_arlock), .s_arqos(s_arqos), .s_arregion(s_arregion),
    .s_aruser(s_aruser), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid), .s_ruser(s_ruser)
`ifdef AXI_DEFAULT_SLV_ERRLOG_EN
    , .err_valid(err_valid), .err_is_wr(err_is_wr), .err_addr(err_addr), .err_clr(err_clr)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  typedef struct packed {logic [3:0] id; logic last;} rexp_t;
  logic [3:0] bq[$];
  rexp_t      rq[$];

  // Scoreboard monitor: pops on each B/R handshake, checks holding stability while stalled
  logic        b_stall_prev = 1'b0, r_stall_prev = 1'b0;
  logic [63:0] b_prev, r_prev;
  logic [3:0]  be;
  rexp_t       re;
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      b_stall_prev = 1'b0;
      r_stall_prev = 1'b0;
    end else begin
      if (b_stall_prev) chk("b_stable", {57'd0, s_bwvalid, s_bid, s_bresp}, b_prev);
      if (r_stall_prev) chk("r_stable", {24'd0, s_rvalid, s_rid, s_rlast, s_rdata, s_rresp}, r_prev);
      b_stall_prev = s_bwvalid && !s_bwready;
      r_stall_prev = s_rvalid && !s_rready;
      b_prev = {57'd0, s_bwvalid, s_bid, s_bresp};
      r_prev = {24'd0, s_rvalid, s_rid, s_rlast, s_rdata, s_rresp};
      if (s_bwvalid && s_bwready) begin
        if (bq.size() == 0) note_fail("b_unexpected");
        else begin
          be = bq.pop_front();
          chk("bid", {60'd0, s_bid}, {60'd0, be});
          chk("bresp", {62'd0, s_bresp}, 64'd3);
        end
      end
      if (s_rvalid && s_rready) begin
        if (rq.size() == 0) note_fail("r_unexpected");
        else begin
          re = rq.pop_front();
          chk("rid", {60'd0, s_rid}, {60'd0, re.id});
          chk("rlast", {63'd0, s_rlast}, {63'd0, re.last});
          chk("rdata", {32'd0, s_rdata}, 64'd0);
          chk("rresp", {62'd0, s_rresp}, 64'd3);
        end
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input int len, input logic [31:0] addr,
                          input int stall_d, input int stall_b, output int beats);
    int n;
    logic hs;
    beats = 0;
    s_awaddr = addr; s_awid = id; s_awlen = len[7:0]; s_awvalid = 1'b1;
    n = 0;
    while (!s_awready && n < 100) begin tick(); n++; end
    if (!s_awready) begin s_awvalid = 1'b0; note_fail("aw_wait"); return; end
    tick();
    s_awvalid = 1'b0;
    chk("wready_after_aw", {63'd0, s_wready}, 64'd1);
    chk("awready_in_wdata", {63'd0, s_awready}, 64'd0);
    bq.push_back(id);
    n = 0;
    while (beats <= len && n < 2000) begin
      s_wvalid = (stall_d == 0) || ((n % (stall_d + 1)) == 0);
      s_wlast = (beats == len);
      s_wdata = $urandom;
      hs = s_wvalid && s_wready;
      tick();
      if (hs) beats++;
      n++;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (beats <= len) begin note_fail("w_drain"); return; end
    chk("bvalid_after_wlast", {63'd0, s_bwvalid}, 64'd1);
    chk("wready_in_resp", {63'd0, s_wready}, 64'd0);
    for (int i = 0; i < stall_b; i++) begin
      chk("awready_during_b", {63'd0, s_awready}, 64'd0);
      tick();
    end
    s_bwready = 1'b1;
    tick();
    s_bwready = 1'b0;
    chk("awready_after_b", {63'd0, s_awready}, 64'd1);
    chk("bvalid_after_b", {63'd0, s_bwvalid}, 64'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input int len, input logic [31:0] addr,
                         input int stall_r, output int beats);
    int n;
    logic hs;
    beats = 0;
    s_araddr = addr; s_arid = id; s_arlen = len[7:0]; s_arvalid = 1'b1;
    n = 0;
    while (!s_aready && n < 100) begin tick(); n++; end
    if (!s_aready) begin s_arvalid = 1'b0; note_fail("ar_wait"); return; end
    tick();
    s_arvalid = 1'b0;
    chk("rvalid_after_ar", {63'd0, s_rvalid}, 64'd1);
    chk("aready_in_rdata", {63'd0, s_aready}, 64'd0);
    for (int i = 0; i <= len; i++) rq.push_back('{id: id, last: (i == len)});
    n = 0;
    while (beats <= len && n < 4000) begin
      s_rready = (stall_r == 0) || ((n % (stall_r + 1)) == stall_r);
      hs = s_rvalid && s_rready;
      tick();
      if (hs) beats++;
      n++;
    end
    s_rready = 1'b0;
    chk("rvalid_after_last", {63'd0, s_rvalid}, 64'd0);
    chk("aready_after_last", {63'd0, s_aready}, 64'd1);
  endtask

  typedef struct {
    bit         rd;
    logic [3:0] id;
    int         len;
    int         stall_d;
    int         stall_b;
    int         exp_beats;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int b1, b2;
    vecs[0] = '{1'b0, 4'd3,  0, 0, 0, 1};
    vecs[1] = '{1'b0, 4'd9,  3, 0, 5, 4};
    vecs[2] = '{1'b1, 4'd5,  7, 1, 0, 8};
    vecs[3] = '{1'b1, 4'd2,  0, 0, 0, 1};
    vecs[4] = '{1'b0, 4'd15, 1, 1, 0, 2};
    vecs[5] = '{1'b1, 4'd10, 2, 2, 0, 3};

    aresetn = 1'b0;
    s_awvalid = 1'b0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_awcache = '0; s_awprot = '0; s_awlock = 1'b0; s_awqos = '0; s_awregion = '0; s_awuser = '0;
    s_wvalid = 1'b0; s_wlast = 1'b0; s_wdata = '0; s_wstrb = '1; s_wuser = '0; s_bwready = 1'b0;
    s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arcache = '0; s_arprot = '0; s_arlock = 1'b0; s_arqos = '0; s_arregion = '0; s_aruser = '0;
    s_rready = 1'b0;
`ifdef AXI_DEFAULT_SLV_ERRLOG_EN
    err_clr = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_awready", {63'd0, s_awready}, 64'd1);
    chk("rst_wready", {63'd0, s_wready}, 64'd0);
    chk("rst_bvalid", {63'd0, s_bwvalid}, 64'd0);
    chk("rst_aready", {63'd0, s_aready}, 64'd1);
    chk("rst_rvalid", {63'd0, s_rvalid}, 64'd0);
    chk("rst_rlast", {63'd0, s_rlast}, 64'd0);
    chk("rst_ids", {56'd0, s_bid, s_rid}, 64'd0);
    aresetn = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].rd) do_read(vecs[v].id, vecs[v].len, 32'h0, vecs[v].stall_d, b1);
      else do_write(vecs[v].id, vecs[v].len, 32'h0, vecs[v].stall_d, vecs[v].stall_b, b1);
      chk($sformatf("vec%0d_beats", v), b1, vecs[v].exp_beats);
      tick();
    end

    fork
      do_read(4'd7, 255, 32'h0, 0, b1);
      do_write(4'd4, 1, 32'h0, 0, 2, b2);
    join
    chk("long_read_beats", b1, 256);
    chk("conc_write_beats", b2, 2);
    tick();

    // Reset in the middle of a 16-beat read
    s_arid = 4'd6; s_arlen = 8'd15; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    for (int i = 0; i < 16; i++) rq.push_back('{id: 4'd6, last: (i == 15)});
    s_rready = 1'b1;
    repeat (4) tick();
    s_rready = 1'b0;
    aresetn = 1'b0;
    tick();
    chk("midrst_rvalid", {63'd0, s_rvalid}, 64'd0);
    chk("midrst_aready", {63'd0, s_aready}, 64'd1);
    chk("midrst_rid", {60'd0, s_rid}, 64'd0);
    aresetn = 1'b1;
    rq.delete();
    s_rready = 1'b1;
    b1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_rvalid) b1++;
      tick();
    end
    s_rready = 1'b0;
    chk("midrst_no_beats", b1, 0);

`ifdef AXI_DEFAULT_SLV_ERRLOG_EN
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("log_cleared", {63'd0, err_valid}, 64'd0);
    do_read(4'd1, 0, 32'h4000_0000, 0, b1);
    do_write(4'd2, 0, 32'h5000_0000, 0, 0, b2);
    chk("log_addr_rd", {32'd0, err_addr}, 64'h4000_0000);
    chk("log_is_wr_rd", {63'd0, err_is_wr}, 64'd0);
    chk("log_valid_rd", {63'd0, err_valid}, 64'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("log_clr", {63'd0, err_valid}, 64'd0);
    do_write(4'd3, 0, 32'h6000_0000, 0, 0, b2);
    chk("log_addr_wr", {32'd0, err_addr}, 64'h6000_0000);
    chk("log_is_wr_wr", {63'd0, err_is_wr}, 64'd1);
    chk("log_valid_wr", {63'd0, err_valid}, 64'd1);
`endif

    repeat (3) tick();
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
